// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose
//   Shares one unified instruction/data memory between three requesters:
//   instruction fetch (IF), data access (DM) and the board debug read port
//   (DBG). Each requester uses a req/ack handshake. One access at a time is
//   granted, the backend is driven for MEM_LAT cycles, then a one-cycle ack
//   returns the read data to the owner.
//
//   Per access:
//     IDLE --(winner sampled)--> BUSY (MEM_LAT cycles) --> RESP (ack) --> IDLE
//   so a request sampled in cycle 0 is acked in cycle MEM_LAT+1, and
//   back-to-back accesses are MEM_LAT+2 cycles apart.
//
// Parameters
//   ADDR_W   address width (byte address, passed through unchanged)
//   DATA_W   data width
//   MEM_LAT  backend read latency in cycles, legal range 1..15
//
// Configuration macro
//   ARB_RR_EN  defined:   round-robin over IF -> DM -> DBG, starting after
//                         the last owner (pointer resets to DBG).
//              undefined: fixed priority DM > IF > DBG, no pointer register.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   if_req/if_addr/if_ack       instruction fetch port (read only)
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_ack             data port (read or write)
//   dbg_req/dbg_addr/dbg_ack    debug port (read only)
//   rdata                       shared read data, valid with the matching ack
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory backend interface
//   grant                       current owner: 0 none, 1 IF, 2 DM, 3 DBG
//   busy                        high while an access is in BUSY or RESP
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IF   = 2'd1;
  localparam logic [1:0] G_DM   = 2'd2;
  localparam logic [1:0] G_DBG  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_e            state_q, state_d;
  logic [1:0]        winner;
  logic [3:0]        cnt;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // -------------------------------------------------------------------------
  // Arbitration: winner among the currently raised requests (G_NONE if none)
  // -------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic [1:0] last_owner;

  // Search order starts at the requester after the last owner, wrapping
  // around IF -> DM -> DBG -> IF.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = G_NONE;
    case (last_owner)
      G_IF: begin
        if      (dm_req)  winner = G_DM;
        else if (dbg_req) winner = G_DBG;
        else if (if_req)  winner = G_IF;
      end
      G_DM: begin
        if      (dbg_req) winner = G_DBG;
        else if (if_req)  winner = G_IF;
        else if (dm_req)  winner = G_DM;
      end
      default: begin
        if      (if_req)  winner = G_IF;
        else if (dm_req)  winner = G_DM;
        else if (dbg_req) winner = G_DBG;
      end
    endcase
  end

  // The pointer moves only when a grant is actually issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_owner <= G_DBG;
    end else if (state_q == IDLE && winner != G_NONE) begin
      last_owner <= winner;
    end
  end
`else
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = G_NONE;
    if      (dm_req)  winner = G_DM;
    else if (if_req)  winner = G_IF;
    else if (dbg_req) winner = G_DBG;
  end
`endif

  // -------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // -------------------------------------------------------------------------
  // NOTE: reset is synchronous here: RST is only looked at on a CLK edge, so
  // it lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (winner != G_NONE) state_d = BUSY;
      BUSY:    if (cnt == 4'd1)      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Access registers: latched request, latency counter, owner, read data.
  // Requester inputs are only looked at in IDLE, so later changes (including
  // a dropped req) do not disturb an access already in flight.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (RST) begin
      grant     <= G_NONE;
      cnt       <= '0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winner != G_NONE) begin
            grant <= winner;
            cnt   <= LAT_LOAD;
            case (winner)
              G_DM: begin
                acc_we    <= dm_we;
                acc_addr  <= dm_addr;
                acc_wdata <= dm_wdata;
              end
              G_IF: begin
                acc_we    <= 1'b0;
                acc_addr  <= if_addr;
                acc_wdata <= '0;
              end
              default: begin
                acc_we    <= 1'b0;
                acc_addr  <= dbg_addr;
                acc_wdata <= '0;
              end
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // Last BUSY cycle: the backend data is valid now. Writes leave
          // rdata holding the previous read.
          if (cnt == 4'd1 && !acc_we) rdata <= mem_rdata;
        end
        default: begin
          grant <= G_NONE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Enables and acks decode from the state register, so a reset
  // drops mem_en/mem_we on the same edge and aborts without an ack.
  // -------------------------------------------------------------------------
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_en & acc_we;
  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;

  assign if_ack    = (state_q == RESP) && (grant == G_IF);
  assign dm_ack    = (state_q == RESP) && (grant == G_DM);
  assign dbg_ack   = (state_q == RESP) && (grant == G_DBG);

  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances:
//   u_lat1 (MEM_LAT=1) for the single-cycle read path,
//   u_lat3 (MEM_LAT=3) for writes, arbitration, starvation, reset and
//   dropped-request scenarios.
// Inputs are driven and outputs sampled 1 time unit after the rising edge;
// "cycle n" means n rising edges after the cycle in which a request is first
// presented.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef ARB_RR_EN
  localparam int EXP_PRI_IF    = 4;
  localparam int EXP_PRI_DM    = 9;
  localparam int EXP_STV_DBG_N = 1;
  localparam int EXP_STV_IF_N  = 19;
  localparam int EXP_STV_FIRST = 9;
`else
  localparam int EXP_PRI_IF    = 9;
  localparam int EXP_PRI_DM    = 4;
  localparam int EXP_STV_DBG_N = 0;
  localparam int EXP_STV_IF_N  = 20;
  localparam int EXP_STV_FIRST = -1;
`endif
  localparam int EXP_PRI_DBG = 14;

  // ---------------- MEM_LAT = 1 instance ----------------
  logic        a_rst, a_if_req, a_dm_req, a_dm_we, a_dbg_req;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata, a_dbg_addr;
  logic        a_if_ack, a_dm_ack, a_dbg_ack, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_grant;

  assign a_mem_rdata = (a_mem_en && a_mem_addr == 32'h4) ? 32'h2001_0005 : 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .CLK(clk), .RST(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_ack(a_dm_ack),
    .dbg_req(a_dbg_req), .dbg_addr(a_dbg_addr), .dbg_ack(a_dbg_ack),
    .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .grant(a_grant), .busy(a_busy)
  );

  // ---------------- MEM_LAT = 3 instance ----------------
  logic        b_rst, b_if_req, b_dm_req, b_dm_we, b_dbg_req;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_dbg_addr;
  logic        b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_grant;
  logic [31:0] b_mem [16];

  assign b_mem_rdata = b_mem_en ? b_mem[b_mem_addr[5:2]] : 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .CLK(clk), .RST(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_ack(b_dm_ack),
    .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_ack(b_dbg_ack),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .grant(b_grant), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    a_rst = 1'b1;
    b_rst = 1'b1;
    step();
    step();
    checks++;
    if ({b_grant, b_busy, b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we} !== 8'b0) begin
      errors++;
      $display("FAIL reset_b_ctrl: got %b expected %b",
               {b_grant, b_busy, b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we}, 8'b0);
    end
    checks++;
    if ({b_mem_addr, b_mem_wdata, b_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_b_data: got addr %h wdata %h rdata %h expected all 0",
               b_mem_addr, b_mem_wdata, b_rdata);
    end
    checks++;
    if ({a_grant, a_busy, a_if_ack, a_dm_ack, a_dbg_ack, a_mem_en, a_mem_we} !== 8'b0) begin
      errors++;
      $display("FAIL reset_a_ctrl: got %b expected %b",
               {a_grant, a_busy, a_if_ack, a_dm_ack, a_dbg_ack, a_mem_en, a_mem_we}, 8'b0);
    end
    a_rst = 1'b0;
    b_rst = 1'b0;
    step();
    checks++;
    if ({b_busy, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_no_req: got busy %b expected 00", {b_busy, a_busy});
    end
  endtask

  // ---------------------------------------------------------------------
  // MEM_LAT=1 IF read: ack at cycle 2, mem_en for exactly cycle 1.
  task automatic test_lat1_read();
    logic [6:0] obs, exp;
    a_if_addr = 32'h0000_0004;
    a_if_req  = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) step();
      // {if_ack, other acks, mem_en, mem_we, grant, busy}
      case (n)
        1:       exp = {1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        2:       exp = {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        default: exp = 7'b0;
      endcase
      obs = {a_if_ack, a_dm_ack | a_dbg_ack, a_mem_en, a_mem_we, a_grant, a_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lat1_cycle%0d: got %b expected %b", n, obs, exp);
      end
      if (n == 1) begin
        checks++;
        if (a_mem_addr !== 32'h4) begin
          errors++;
          $display("FAIL lat1_addr: got %h expected %h", a_mem_addr, 32'h4);
        end
      end
      if (n == 2) begin
        checks++;
        if (a_rdata !== 32'h2001_0005) begin
          errors++;
          $display("FAIL lat1_rdata: got %h expected %h", a_rdata, 32'h2001_0005);
        end
        a_if_req = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // All three requests raised together, each dropped on its own ack.
  task automatic test_priority();
    int ack_at [3];
    int ack_n  [3];
    logic [2:0] acks;
    for (int i = 0; i < 3; i++) begin
      ack_at[i] = -1;
      ack_n[i]  = 0;
    end
    b_dm_we   = 1'b0;
    b_dm_addr = 32'h20;
    b_if_addr = 32'h24;
    b_dbg_addr = 32'h28;
    b_dm_req  = 1'b1;
    b_if_req  = 1'b1;
    b_dbg_req = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) step();
      acks = {b_if_ack, b_dm_ack, b_dbg_ack};
      checks++;
      if ($countones(acks) > 1) begin
        errors++;
        $display("FAIL pri_onehot_cycle%0d: got acks %b expected at most one", n, acks);
      end
      if (b_if_ack) begin
        ack_at[0] = n;
        ack_n[0]++;
        b_if_req = 1'b0;
        checks++;
        if (b_rdata !== 32'hB000_0024) begin
          errors++;
          $display("FAIL pri_if_rdata: got %h expected %h", b_rdata, 32'hB000_0024);
        end
      end
      if (b_dm_ack) begin
        ack_at[1] = n;
        ack_n[1]++;
        b_dm_req = 1'b0;
        checks++;
        if (b_rdata !== 32'hA000_0020) begin
          errors++;
          $display("FAIL pri_dm_rdata: got %h expected %h", b_rdata, 32'hA000_0020);
        end
      end
      if (b_dbg_ack) begin
        ack_at[2] = n;
        ack_n[2]++;
        b_dbg_req = 1'b0;
        checks++;
        if (b_rdata !== 32'hC000_0028) begin
          errors++;
          $display("FAIL pri_dbg_rdata: got %h expected %h", b_rdata, 32'hC000_0028);
        end
      end
    end
    checks++;
    if (ack_at[0] != EXP_PRI_IF || ack_n[0] != 1) begin
      errors++;
      $display("FAIL pri_if_order: got cycle %0d count %0d expected cycle %0d count 1",
               ack_at[0], ack_n[0], EXP_PRI_IF);
    end
    checks++;
    if (ack_at[1] != EXP_PRI_DM || ack_n[1] != 1) begin
      errors++;
      $display("FAIL pri_dm_order: got cycle %0d count %0d expected cycle %0d count 1",
               ack_at[1], ack_n[1], EXP_PRI_DM);
    end
    checks++;
    if (ack_at[2] != EXP_PRI_DBG || ack_n[2] != 1) begin
      errors++;
      $display("FAIL pri_dbg_order: got cycle %0d count %0d expected cycle %0d count 1",
               ack_at[2], ack_n[2], EXP_PRI_DBG);
    end
  endtask

  // ---------------------------------------------------------------------
  // MEM_LAT=3 DM write: enables for cycles 1..3, ack at 4, rdata untouched.
  task automatic test_dm_write();
    logic [6:0] obs, exp;
    b_dm_we    = 1'b1;
    b_dm_addr  = 32'h10;
    b_dm_wdata = 32'hDEAD_BEEF;
    b_dm_req   = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) step();
      // {dm_ack, other acks, mem_en, mem_we, grant, busy}
      case (n)
        1, 2, 3: exp = {1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
        4:       exp = {1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};
        default: exp = 7'b0;
      endcase
      obs = {b_dm_ack, b_if_ack | b_dbg_ack, b_mem_en, b_mem_we, b_grant, b_busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wr_cycle%0d: got %b expected %b", n, obs, exp);
      end
      if (n >= 1 && n <= 3) begin
        checks++;
        if (b_mem_addr !== 32'h10 || b_mem_wdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL wr_bus_cycle%0d: got addr %h data %h expected %h %h",
                   n, b_mem_addr, b_mem_wdata, 32'h10, 32'hDEAD_BEEF);
        end
      end
      if (n == 4) begin
        b_dm_req = 1'b0;
        b_dm_we  = 1'b0;
      end
      if (n >= 4) begin
        checks++;
        if (b_rdata !== 32'hC000_0028) begin
          errors++;
          $display("FAIL wr_rdata_kept_cycle%0d: got %h expected %h", n, b_rdata, 32'hC000_0028);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Continuous IF fetch with a pending debug read.
  task automatic test_starvation();
    int if_n, dbg_n, dbg_first;
    if_n = 0;
    dbg_n = 0;
    dbg_first = -1;
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    b_if_addr  = 32'h24;
    b_dbg_addr = 32'h28;
    b_if_req   = 1'b1;
    b_dbg_req  = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) step();
      if (b_if_ack) if_n++;
      if (b_dbg_ack) begin
        dbg_n++;
        if (dbg_first < 0) dbg_first = n;
        b_dbg_req = 1'b0;
      end
    end
    b_if_req  = 1'b0;
    b_dbg_req = 1'b0;
    checks++;
    if (dbg_n != EXP_STV_DBG_N || dbg_first != EXP_STV_FIRST) begin
      errors++;
      $display("FAIL starve_dbg: got %0d acks first at %0d expected %0d acks first at %0d",
               dbg_n, dbg_first, EXP_STV_DBG_N, EXP_STV_FIRST);
    end
    checks++;
    if (if_n != EXP_STV_IF_N) begin
      errors++;
      $display("FAIL starve_if_count: got %0d expected %0d", if_n, EXP_STV_IF_N);
    end
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_drain: got busy %b expected 0", b_busy);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reset in the second BUSY cycle of a DM write aborts it without an ack.
  task automatic test_reset_busy();
    int ack_cnt;
    ack_cnt = 0;
    b_dm_we    = 1'b1;
    b_dm_addr  = 32'h30;
    b_dm_wdata = 32'hCAFE_F00D;
    b_dm_req   = 1'b1;
    step();
    step();
    checks++;
    if ({b_mem_en, b_mem_we, b_grant, b_busy} !== {1'b1, 1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL rstbusy_pre: got %b expected %b",
               {b_mem_en, b_mem_we, b_grant, b_busy}, {1'b1, 1'b1, 2'd2, 1'b1});
    end
    b_rst    = 1'b1;
    b_dm_req = 1'b0;
    b_dm_we  = 1'b0;
    step();
    b_rst = 1'b0;
    checks++;
    if ({b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we, b_grant, b_busy} !== 8'b0) begin
      errors++;
      $display("FAIL rstbusy_post: got %b expected %b",
               {b_if_ack, b_dm_ack, b_dbg_ack, b_mem_en, b_mem_we, b_grant, b_busy}, 8'b0);
    end
    checks++;
    if ({b_rdata, b_mem_addr, b_mem_wdata} !== 96'h0) begin
      errors++;
      $display("FAIL rstbusy_data: got rdata %h addr %h wdata %h expected all 0",
               b_rdata, b_mem_addr, b_mem_wdata);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (b_if_ack || b_dm_ack || b_dbg_ack || b_busy) ack_cnt++;
    end
    checks++;
    if (ack_cnt != 0) begin
      errors++;
      $display("FAIL rstbusy_quiet: got %0d active cycles expected 0", ack_cnt);
    end
  endtask

  // ---------------------------------------------------------------------
  // One-cycle debug request still completes exactly once.
  task automatic test_dbg_pulse();
    int en_cnt;
    logic exp_ack;
    en_cnt = 0;
    b_dbg_addr = 32'h8;
    b_dbg_req  = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      if (n > 0) step();
      if (n == 1) b_dbg_req = 1'b0;
      if (b_mem_en) en_cnt++;
      exp_ack = (n == 4);
      checks++;
      if (b_dbg_ack !== exp_ack) begin
        errors++;
        $display("FAIL dbgpulse_ack_cycle%0d: got %b expected %b", n, b_dbg_ack, exp_ack);
      end
      if (n == 2) begin
        checks++;
        if (b_grant !== 2'd3) begin
          errors++;
          $display("FAIL dbgpulse_grant: got %0d expected 3", b_grant);
        end
      end
      if (n == 4) begin
        checks++;
        if (b_rdata !== 32'h0000_D8D8) begin
          errors++;
          $display("FAIL dbgpulse_rdata: got %h expected %h", b_rdata, 32'h0000_D8D8);
        end
      end
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL dbgpulse_en_cycles: got %0d expected 3", en_cnt);
    end
  endtask

  // ---------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 16; i++) b_mem[i] = 32'h0;
    b_mem[2]  = 32'h0000_D8D8;
    b_mem[4]  = 32'h1111_1111;
    b_mem[8]  = 32'hA000_0020;
    b_mem[9]  = 32'hB000_0024;
    b_mem[10] = 32'hC000_0028;
    b_mem[12] = 32'h0;

    a_rst = 1'b1; a_if_req = 1'b0; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dbg_req = 1'b0;
    a_if_addr = '0; a_dm_addr = '0; a_dm_wdata = '0; a_dbg_addr = '0;
    b_rst = 1'b1; b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dbg_req = 1'b0;
    b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0; b_dbg_addr = '0;

    test_reset();
    test_lat1_read();
    test_priority();
    test_dm_write();
    test_starvation();
    test_reset_busy();
    test_dbg_pulse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
